// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the SR flag arbiter: command encodings, FSM state
// type and a clog2 helper that never returns zero (for 1-bit minimum widths).
package sr_flag_arbiter_pkg;

    localparam logic [1:0] CMD_NOP = 2'b00;
    localparam logic [1:0] CMD_CLR = 2'b01;
    localparam logic [1:0] CMD_SET = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible requester scanning upward
// from ptr with wrap-around. Reports one-hot winner, its index and a valid bit.
module rr_picker
    import sr_flag_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = clog2_min1(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [SW-1:0] winner_idx,
    output logic          valid
);

    // Scan from ptr, wrapping at N-1; the first hit wins.
    always_comb begin
        int            c;
        logic [SW-1:0] ci;
        winner     = '0;
        winner_idx = '0;
        valid      = 1'b0;
        c          = 0;
        ci         = '0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) c = c - N;
            ci = SW'(c);
            if (!valid && eligible[ci]) begin
                valid      = 1'b1;
                winner[ci] = 1'b1;
                winner_idx = ci;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of W SR flag cells shared by N requesters through a registered
// round-robin arbiter; one command applied per clock.
// Optional build macro SR_FLAG_ARBITER_LOCK_EN adds a per-requester lock
// input that lets the current winner keep issuing back-to-back commands.
//
//   state | meaning
//   IDLE  | no grant this cycle (gnt == 0)
//   GRANT | one-hot grant issued, command applied at the same edge
module sr_flag_arbiter
    import sr_flag_arbiter_pkg::*;
#(
    parameter int   N         = 4,
    parameter int   W         = 8,
    parameter logic RESET_VAL = 1'b0,
    localparam int  IDXW      = clog2_min1(W),
    localparam int  SW        = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    cmd_s,
    input  logic [N-1:0]    cmd_r,
    input  logic [N*IDXW-1:0] cmd_idx,
`ifdef SR_FLAG_ARBITER_LOCK_EN
    input  logic [N-1:0]    lock,
`endif
    input  logic            err_clr,
    output logic [N-1:0]    gnt,
    output logic [W-1:0]    flags,
    output logic [W-1:0]    flags_b,
    output logic            err,
    output logic [SW-1:0]   err_src,
    output logic            busy
);

    state_t        state, next_state;
    logic [N-1:0]  eligible, win_oh;
    logic [SW-1:0] ptr, win_idx;
    logic          win_valid;
    logic [1:0]    win_cmd;
    logic [IDXW-1:0] win_fidx;
    logic          idx_bad, new_err;

`ifdef SR_FLAG_ARBITER_LOCK_EN
    logic lock_q;
    logic hold;

    // A locked winner that still requests with lock high stays the only
    // eligible requester; otherwise the just-granted requester is masked.
    assign hold     = lock_q && |(gnt & req & lock);
    assign eligible = hold ? (req & gnt) : (req & ~gnt);
`else
    // Masking the current grant forces the req-drop handshake.
    assign eligible = req & ~gnt;
`endif

    rr_picker #(.N(N), .SW(SW)) u_picker (
        .eligible   (eligible),
        .ptr        (ptr),
        .winner     (win_oh),
        .winner_idx (win_idx),
        .valid      (win_valid)
    );

    // Decode the winner's command and flag the illegal / out-of-range cases.
    always_comb begin
        win_cmd  = {cmd_s[win_idx], cmd_r[win_idx]};
        win_fidx = cmd_idx[int'(win_idx)*IDXW +: IDXW];
        idx_bad  = {1'b0, win_fidx} >= (IDXW+1)'(W);
        new_err  = win_valid && ((win_cmd == CMD_ILL) || idx_bad);
    end

    // Next state: grant whenever enabled and someone is eligible.
    always_comb begin
        next_state = IDLE;
        if (enable && win_valid) next_state = GRANT;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Registered one-hot grant; dropped whenever enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    gnt <= '0;
        else if (enable && win_valid) gnt <= win_oh;
        else                          gnt <= '0;
    end

    // Pointer, flag bank and sticky error, all frozen while enable is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            flags   <= {W{RESET_VAL}};
            err     <= 1'b0;
            err_src <= '0;
`ifdef SR_FLAG_ARBITER_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else if (enable) begin
            if (win_valid) begin
`ifdef SR_FLAG_ARBITER_LOCK_EN
                if (!lock[win_idx])
`endif
                    ptr <= (win_idx == SW'(N-1)) ? '0 : win_idx + SW'(1);
                if (!idx_bad) begin
                    case (win_cmd)
                        CMD_CLR: flags[win_fidx] <= 1'b0;
                        CMD_SET: flags[win_fidx] <= 1'b1;
                        default: ;
                    endcase
                end
            end
            // A clear coinciding with a new error leaves err set and
            // records the new source.
            if (err_clr) begin
                err     <= new_err;
                err_src <= new_err ? win_idx : '0;
            end else if (new_err) begin
                err <= 1'b1;
                if (!err) err_src <= win_idx;
            end
`ifdef SR_FLAG_ARBITER_LOCK_EN
            lock_q <= win_valid && lock[win_idx];
`endif
        end
    end

    assign flags_b = ~flags;
    assign busy    = (state == GRANT);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: main instance N=4/W=8 plus a W=6
// instance sharing the same stimulus to reach out-of-range indices.
module tb_sr_flag_arbiter;
    import sr_flag_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int IW = 3;

    logic             clk = 1'b0;
    logic             reset, enable, err_clr;
    logic [N-1:0]     req, cmd_s, cmd_r;
    logic [N*IW-1:0]  cmd_idx;
`ifdef SR_FLAG_ARBITER_LOCK_EN
    logic [N-1:0]     lock = '0;
`endif

    logic [N-1:0] gnt, gnt6;
    logic [7:0]   flags, flags_b;
    logic [5:0]   flags6, flags_b6;
    logic         err, err6, busy, busy6;
    logic [1:0]   err_src, err_src6;

    int n_checks = 0;
    int n_errors = 0;

    sr_flag_arbiter #(.N(N), .W(8), .RESET_VAL(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .req(req),
        .cmd_s(cmd_s), .cmd_r(cmd_r), .cmd_idx(cmd_idx),
`ifdef SR_FLAG_ARBITER_LOCK_EN
        .lock(lock),
`endif
        .err_clr(err_clr), .gnt(gnt), .flags(flags), .flags_b(flags_b),
        .err(err), .err_src(err_src), .busy(busy)
    );

    sr_flag_arbiter #(.N(N), .W(6), .RESET_VAL(1'b0)) dut6 (
        .clk(clk), .reset(reset), .enable(enable), .req(req),
        .cmd_s(cmd_s), .cmd_r(cmd_r), .cmd_idx(cmd_idx),
`ifdef SR_FLAG_ARBITER_LOCK_EN
        .lock(lock),
`endif
        .err_clr(err_clr), .gnt(gnt6), .flags(flags6), .flags_b(flags_b6),
        .err(err6), .err_src(err_src6), .busy(busy6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic s, input logic r, input int idx);
        cmd_s[i] = s;
        cmd_r[i] = r;
        cmd_idx[i*IW +: IW] = IW'(idx);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; err_clr = 1'b0;
        req = '0; cmd_s = '0; cmd_r = '0; cmd_idx = '0;
        #2;
        check("rst_flags",   32'(flags),   32'h00);
        check("rst_flags_b", 32'(flags_b), 32'hFF);
        check("rst_gnt",     32'(gnt),     32'h0);
        check("rst_err",     32'(err),     32'h0);
        check("rst_busy",    32'(busy),    32'h0);
        @(negedge clk); reset = 1'b0;

        // single set then clear of flag 5 by requester 2
        set_cmd(2, 1'b1, 1'b0, 5); req = 4'b0100;
        tick;
        check("set_gnt",     32'(gnt),     32'h4);
        check("set_flags",   32'(flags),   32'h20);
        check("set_flags_b", 32'(flags_b), 32'hDF);
        check("set_busy",    32'(busy),    32'h1);
        req = '0;
        tick;
        check("set_gnt_off", 32'(gnt),  32'h0);
        check("set_busy_off",32'(busy), 32'h0);
        set_cmd(2, 1'b0, 1'b1, 5); req = 4'b0100;
        tick;
        check("clr_gnt",   32'(gnt),   32'h4);
        check("clr_flags", 32'(flags), 32'h00);
        req = '0;
        tick;

        // async reset asserted while a grant is showing
        set_cmd(3, 1'b1, 1'b0, 6); req = 4'b1000;
        tick;
        check("pre_rst_gnt",   32'(gnt),   32'h8);
        check("pre_rst_flags", 32'(flags), 32'h40);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_gnt",     32'(gnt),     32'h0);
        check("mid_rst_flags",   32'(flags),   32'h00);
        check("mid_rst_flags_b", 32'(flags_b), 32'hFF);
        req = '0;
        @(negedge clk); reset = 1'b0;

        // round robin: all request, granted one drops for a cycle
        cmd_s = '0; cmd_r = '0; cmd_idx = '0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("rr_gnt",  32'(gnt),  32'(1) << (k % 4));
            check("rr_busy", 32'(busy), 32'h1);
            req = 4'b1111 & ~(4'(1) << (k % 4));
        end
        check("rr_flags", 32'(flags), 32'h00);
        req = '0;
        tick;
        check("rr_idle", 32'(gnt), 32'h0);

        // illegal command from requester 1, then clear
        set_cmd(1, 1'b1, 1'b1, 3); req = 4'b0010;
        tick;
        check("ill_gnt",     32'(gnt),     32'h2);
        check("ill_flags",   32'(flags),   32'h00);
        check("ill_err",     32'(err),     32'h1);
        check("ill_err_src", 32'(err_src), 32'h1);
        check("ill_err6",    32'(err6),    32'h1);
        req = '0;
        tick;
        check("ill_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        check("clr_err",     32'(err),     32'h0);
        check("clr_err_src", 32'(err_src), 32'h0);
        check("clr_err6",    32'(err6),    32'h0);

        // index 7: legal for W=8, out of range for W=6
        set_cmd(0, 1'b1, 1'b0, 7); req = 4'b0001;
        tick;
        check("oor_gnt",      32'(gnt),      32'h1);
        check("oor_flags",    32'(flags),    32'h80);
        check("oor_err",      32'(err),      32'h0);
        check("oor_gnt6",     32'(gnt6),     32'h1);
        check("oor_flags6",   32'(flags6),   32'h00);
        check("oor_err6",     32'(err6),     32'h1);
        check("oor_err_src6", 32'(err_src6), 32'h0);
        req = '0;
        tick;

        // err_clr coinciding with a new illegal command from requester 3
        set_cmd(3, 1'b1, 1'b1, 0); req = 4'b1000; err_clr = 1'b1;
        tick;
        err_clr = 1'b0; req = '0;
        check("clrnew_err6",     32'(err6),     32'h1);
        check("clrnew_err_src6", 32'(err_src6), 32'h3);
        check("clrnew_err",      32'(err),      32'h1);
        check("clrnew_err_src",  32'(err_src),  32'h3);
        check("clrnew_flags",    32'(flags),    32'h80);
        tick;

        // enable low holds everything while requests wait
        enable = 1'b0;
        set_cmd(0, 1'b1, 1'b0, 1); set_cmd(1, 1'b1, 1'b0, 2); req = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            tick;
            check("dis_gnt",   32'(gnt),   32'h0);
            check("dis_flags", 32'(flags), 32'h80);
        end
        enable = 1'b1;
        tick;
        check("en_gnt0",   32'(gnt),   32'h1);
        check("en_flags0", 32'(flags), 32'h82);
        req = 4'b0010;
        tick;
        check("en_gnt1",   32'(gnt),   32'h2);
        check("en_flags1", 32'(flags), 32'h86);
        req = '0;
        tick;
        check("end_gnt",  32'(gnt),  32'h0);
        check("end_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Shared bank of W SR-style flag cells, commanded by N requesters through a registered round-robin arbiter.
- Each requester presents a {S,R} command plus a flag index; one command is applied per clock.
- Sits between control agents, such as per-channel sequencers, and a common status/flag register.
- Replaces per-agent direct SR cell instantiation, so concurrent set/clear attempts are serialized deterministically.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, number of flag cells (2..64)
- IDXW, $clog2(W), flag index width (derived localparam, min 1)
- RESET_VAL, 1'b0, value every flag takes on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  active-high; when low, no arbitration, no flag update, all state held
- req  in  N  per-requester request, level; held until own gnt seen
- cmd_s  in  N  per-requester S bit
- cmd_r  in  N  per-requester R bit
- cmd_idx  in  N*IDXW  per-requester flag index; slice i = bits [i*IDXW +: IDXW]
- gnt  out  N  registered one-hot grant, high for exactly one cycle per accepted command
- flags  out  W  flag cell values (Q)
- flags_b  out  W  always bitwise ~flags
- err  out  1  sticky error flag
- err_src  out  $clog2(N) (min 1)  requester index of the first error since last clear
- err_clr  in  1  synchronous clear of err/err_src
- busy  out  1  high in any cycle where gnt is non-zero

Behaviour:
- Reset (async, active-high) drives these values:
  - gnt=0, flags=RESET_VAL all bits, flags_b=~RESET_VAL, err=0, err_src=0.
  - RR pointer=0; FSM returns to IDLE.
  - Any in-flight command is dropped.
- FSM states:
  - IDLE: gnt=0.
  - GRANT: gnt one-hot.
  - Evaluated each edge with enable=1. Next state is GRANT if any eligible req exists, else IDLE.
  - Back-to-back GRANT cycles are allowed when different requesters are pending.
- Eligibility: req[i]=1 and gnt[i]=0 in the current cycle. Masking the just-granted requester enforces the req-drop handshake.
- Selection: first eligible index scanning ptr, ptr+1, ... wrapping N-1 -> 0. On grant, ptr <= winner+1 mod N.
- Latency:
  - Command sampled at edge k.
  - gnt[winner] and flag update both visible after edge k.
  - A requester sees gnt one cycle after its req is sampled.
- Command application at the granting edge, using the winner's cmd_s/cmd_r/cmd_idx:
  - {S,R}=00: grant issued, flag unchanged.
  - {S,R}=01: flags[idx] <= 0.
  - {S,R}=10: flags[idx] <= 1.
  - {S,R}=11: illegal. Flag unchanged, grant still issued, err<=1.
  - cmd_idx >= W: flag unchanged, grant issued, err<=1.
- Error reporting:
  - err_src captures the requester index only when err was 0 and no simultaneous err_clr.
  - err_clr and a new error in the same cycle: err stays 1, err_src takes the new source.
- flags_b: registered with flags, never out of phase.
- enable=0: gnt forced to 0 at next edge; ptr, flags and err held; pending reqs wait.
- Requester dropping req before grant: silently withdrawn, no side effects.

Optional Feature:
- Macro: SR_FLAG_ARBITER_LOCK_EN.
- Enabled:
  - Adds input lock N bits.
  - If the winner had lock[i]=1 when granted, it stays the sole eligible requester and is exempt from the gnt mask.
  - This allows consecutive commands every cycle until it presents a cycle with req=0 or lock=0.
  - ptr is not advanced while locked.
- Disabled: no lock port; behaviour exactly as above.

Decomposition:
- Package sr_flag_arbiter_pkg holds:
  - command constants CMD_NOP=2'b00, CMD_CLR=2'b01, CMD_SET=2'b10, CMD_ILL=2'b11;
  - the state typedef (IDLE, GRANT);
  - a clog2-with-min-1 helper function.
- One natural sub-module, rr_picker: purely combinational.
  - Inputs: eligible vector and ptr.
  - Outputs: one-hot winner plus winner index and valid.

Test Plan:
- Reset priority: reset=1 with RESET_VAL=0 -> flags=8'h00, flags_b=8'hFF, gnt=0. Assert reset mid-GRANT -> gnt=0 immediately (async), no flag update.
- Single set/clear, N=4, W=8: req[2]=1 with {S,R}=10, idx=5 -> gnt=4'b0100 next cycle, flags=8'h20. Then {S,R}=01, idx=5 -> flags=8'h00.
- Round-robin fairness: all four reqs held, each requester dropping req after its grant then re-raising it -> grants 0,1,2,3,0 in consecutive cycles, busy continuously 1.
- Illegal command: req[1] with {S,R}=11, idx=3 -> gnt[1]=1, flags unchanged, err=1, err_src=1. err_clr pulse -> err=0.
- Out-of-range index: W=6, idx=7 -> grant issued, no flag change, err=1.
- enable low: reqs pending with enable=0 for 5 cycles -> gnt=0 and flags stable throughout. Enable=1 -> grant to the requester at ptr.
